// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Keeps the fetch PC, issues in-order requests to instruction memory,
// buffers returned words in a 2-entry queue and presents the head to IF/ID.
// Optional build macro FETCH_PERF_EN adds three 32-bit performance counters.
//
// Memory handshake: a request transfers in a cycle where imem_req and
// imem_gnt are both high (address and request held stable until then);
// responses carry no ready, arrive in request order with latency >= 1 and
// are accepted whenever imem_rvalid is high and a granted request is pending.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCplus4_IF,
  output logic [31:0] Instr_IF,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_bubbles,
`endif
  output logic        Valid_IF
);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] q0_pc4_q, q0_pc4_d, q1_pc4_q, q1_pc4_d;
  logic [31:0] q0_ins_q, q0_ins_d, q1_ins_q, q1_ins_d;
  logic [1:0]  qcount_q, qcount_d;
  logic [1:0]  inflight_q, inflight_d;
  logic [1:0]  drop_q, drop_d;
  logic [31:0] last_pc4_q, last_pc4_d;

  logic        grant, resp, resp_drop, push, pop, discard;
  logic [2:0]  credit_used;
  logic [31:0] redirect_aligned;
  logic        redirect_pc_unused;

  // Misaligned redirect targets are forced onto a word boundary.
  assign redirect_aligned   = {RedirectPC[31:2], 2'b00};
  assign redirect_pc_unused = ^RedirectPC[1:0];

  // Credit rule: queued plus outstanding words never exceed the queue depth.
  assign credit_used = {1'b0, qcount_q} + {1'b0, inflight_q};
  assign imem_req    = Rst_n && !Redirect && (credit_used < 3'd2);
  assign imem_addr   = fpc_q;

  assign grant     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (inflight_q != 2'd0);
  assign resp_drop = resp && (drop_q != 2'd0);
  assign push      = resp && !resp_drop && !Redirect;
  assign discard   = resp && (resp_drop || Redirect);
  assign pop       = !Stall && !Redirect && (qcount_q != 2'd0);

  assign Valid_IF   = (qcount_q != 2'd0) && !Redirect;
  assign Instr_IF   = Valid_IF ? q0_ins_q : NOP_INSTR;
  assign PCplus4_IF = Valid_IF ? q0_pc4_q : last_pc4_q;

  // Next-state for PCs, credit counters and the 2-entry shift queue.
  always_comb begin
    fpc_d      = fpc_q;
    rpc_d      = rpc_q;
    q0_pc4_d   = q0_pc4_q;
    q0_ins_d   = q0_ins_q;
    q1_pc4_d   = q1_pc4_q;
    q1_ins_d   = q1_ins_q;
    qcount_d   = qcount_q;
    last_pc4_d = PCplus4_IF;
    inflight_d = inflight_q + {1'b0, grant} - {1'b0, resp};
    drop_d     = drop_q - {1'b0, resp_drop};

    if (grant) fpc_d = fpc_q + 32'd4;
    if (push)  rpc_d = rpc_q + 32'd4;

    if (Redirect) begin
      // Everything still outstanding after this cycle is wrong-path.
      fpc_d    = redirect_aligned;
      rpc_d    = redirect_aligned;
      qcount_d = 2'd0;
      drop_d   = inflight_d;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (qcount_q == 2'd0) begin
            q0_pc4_d = rpc_q + 32'd4;
            q0_ins_d = imem_rdata;
          end else begin
            q1_pc4_d = rpc_q + 32'd4;
            q1_ins_d = imem_rdata;
          end
          qcount_d = qcount_q + 2'd1;
        end
        2'b01: begin
          q0_pc4_d = q1_pc4_q;
          q0_ins_d = q1_ins_q;
          qcount_d = qcount_q - 2'd1;
        end
        2'b11: begin
          if (qcount_q == 2'd1) begin
            q0_pc4_d = rpc_q + 32'd4;
            q0_ins_d = imem_rdata;
          end else begin
            q0_pc4_d = q1_pc4_q;
            q0_ins_d = q1_ins_q;
            q1_pc4_d = rpc_q + 32'd4;
            q1_ins_d = imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers, cleared asynchronously by Rst_n.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fpc_q      <= RESET_PC;
      rpc_q      <= RESET_PC;
      q0_pc4_q   <= '0;
      q0_ins_q   <= '0;
      q1_pc4_q   <= '0;
      q1_ins_q   <= '0;
      qcount_q   <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      last_pc4_q <= '0;
    end else begin
      fpc_q      <= fpc_d;
      rpc_q      <= rpc_d;
      q0_pc4_q   <= q0_pc4_d;
      q0_ins_q   <= q0_ins_d;
      q1_pc4_q   <= q1_pc4_d;
      q1_ins_q   <= q1_ins_d;
      qcount_q   <= qcount_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      last_pc4_q <= last_pc4_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, push};
    perf_dropped_d = perf_dropped_q + {31'd0, discard};
    perf_bubbles_d = perf_bubbles_q + {31'd0, (!Stall && !Valid_IF)};
  end

  // Counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic discard_unused;
  assign discard_unused = discard;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with programmable latency, an
// expected-PC queue filled by the stimulus and a monitor that checks every
// consumed head, plus directed checks on reset, stall, redirect and grant.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n, Stall, Redirect;
  logic [31:0] RedirectPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic [31:0] PCplus4_IF, Instr_IF;
  logic        Valid_IF;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_bubbles;
  logic [31:0] drop_base;
`endif

  fetch_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCplus4_IF(PCplus4_IF), .Instr_IF(Instr_IF),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_dropped(perf_dropped),
    .perf_bubbles(perf_bubbles),
`endif
    .Valid_IF(Valid_IF)
  );

  // Clock
  always #5 Clk = ~Clk;

  int          checks = 0;
  int          passed = 0;
  int          pops   = 0;
  int          lat    = 1;
  int          cyc    = 0;
  int          last_due = 0;
  int          due_q[$];
  logic [31:0] maddr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] held;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_0000;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_from(logic [31:0] start_pc);
    exp_q.delete();
    for (int i = 1; i <= 200; i++) exp_q.push_back(start_pc + 32'(4 * i));
  endtask

  task automatic wait_valid(string name, int budget);
    int n;
    n = 0;
    while (!Valid_IF && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (Valid_IF) passed++;
    else $display("FAIL %s: Valid_IF still 0 after %0d cycles, required 1", name, budget);
  endtask

  // Memory model: records grants mid-cycle, answers in order after lat cycles.
  always @(negedge Clk) begin : mem_model
    int d;
    cyc++;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(maddr_q[0]);
      void'(due_q.pop_front());
      void'(maddr_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_0000;
    end
    if (imem_req && imem_gnt) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      due_q.push_back(d);
      maddr_q.push_back(imem_addr);
    end
  end

  // Monitor: every head consumed by IF/ID must be the next expected fetch.
  always @(negedge Clk) begin : monitor
    logic [31:0] e;
    if (Rst_n && Valid_IF && !Stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got pc4 %h, required no output", PCplus4_IF);
      end else begin
        e = exp_q.pop_front();
        pops++;
        if (PCplus4_IF === e && Instr_IF === word_of(e - 32'd4)) passed++;
        else $display("FAIL sb_head: got pc4 %h instr %h, required pc4 %h instr %h",
                      PCplus4_IF, Instr_IF, e, word_of(e - 32'd4));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", checks);
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; imem_gnt = 1'b1;
    repeat (3) tick();
    #1;
    check("reset_req", {31'd0, imem_req}, 32'd0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_valid", {31'd0, Valid_IF}, 32'd0);
    check("reset_instr", Instr_IF, 32'h0);
    check("reset_pc4", PCplus4_IF, 32'h0);

    // Release: stream with L = 1
    expect_from(32'h0);
    Rst_n = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    check("second_addr", imem_addr, 32'h4);
    check("valid_c1", {31'd0, Valid_IF}, 32'd0);
    tick();
    check("valid_c2", {31'd0, Valid_IF}, 32'd1);
    check("first_pc4", PCplus4_IF, 32'h4);
    repeat (8) tick();

    // Stall 3 cycles on a valid head
    wait_valid("stall_pre", 10);
    Stall = 1'b1;
    #1;
    held = PCplus4_IF;
    tick();
    check("stall_hold1", PCplus4_IF, held);
    tick();
    check("stall_hold2", PCplus4_IF, held);
    check("stall_valid", {31'd0, Valid_IF}, 32'd1);
    check("stall_req_off", {31'd0, imem_req}, 32'd0);
    tick();
    Stall = 1'b0;
    repeat (8) tick();

    // Grant withheld 4 cycles
    imem_gnt = 1'b0;
    #1;
    held = imem_addr;
    repeat (3) tick();
    check("gw_addr", imem_addr, held);
    check("gw_req", {31'd0, imem_req}, 32'd1);
    check("gw_instr", Instr_IF, 32'h0);
    check("gw_valid", {31'd0, Valid_IF}, 32'd0);
    tick();

    // Redirect with two responses in flight (L = 3)
    lat = 3;
    imem_gnt = 1'b1;
    tick();
    tick();
    Redirect = 1'b1;
    RedirectPC = 32'h100;
    expect_from(32'h100);
`ifdef FETCH_PERF_EN
    drop_base = perf_dropped;
`endif
    #1;
    check("rd_valid", {31'd0, Valid_IF}, 32'd0);
    check("rd_req", {31'd0, imem_req}, 32'd0);
    tick();
    Redirect = 1'b0;
    #1;
    check("rd_addr", imem_addr, 32'h100);
    wait_valid("rd_first", 20);
    check("rd_pc4", PCplus4_IF, 32'h104);
`ifdef FETCH_PERF_EN
    check("rd_dropped", perf_dropped - drop_base, 32'd2);
`endif

    // Redirect together with Stall and grant (L = 2)
    lat = 2;
    repeat (6) tick();
    wait_valid("rs_pre", 10);
    Stall = 1'b1;
    Redirect = 1'b1;
    RedirectPC = 32'h203;
    expect_from(32'h200);
    #1;
    check("rs_valid", {31'd0, Valid_IF}, 32'd0);
    check("rs_req", {31'd0, imem_req}, 32'd0);
    tick();
    Redirect = 1'b0;
    Stall = 1'b0;
    #1;
    check("rs_addr", imem_addr, 32'h200);
    wait_valid("rs_first", 30);
    check("rs_pc4", PCplus4_IF, 32'h204);

    // Reset pulse mid-stream (L = 3); stale responses must be ignored
    lat = 3;
    repeat (8) tick();
    Rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rp_req", {31'd0, imem_req}, 32'd0);
    check("rp_addr", imem_addr, 32'h0);
    check("rp_valid", {31'd0, Valid_IF}, 32'd0);
    check("rp_instr", Instr_IF, 32'h0);
    check("rp_pc4", PCplus4_IF, 32'h0);
    tick();
    Rst_n = 1'b1;
    imem_gnt = 1'b0;
    expect_from(32'h0);
    repeat (4) begin
      #1;
      check("rp_quiet", {31'd0, Valid_IF}, 32'd0);
      tick();
    end
    imem_gnt = 1'b1;
    #1;
    check("rp_refetch_req", {31'd0, imem_req}, 32'd1);
    check("rp_refetch_addr", imem_addr, 32'h0);
    wait_valid("rp_first", 20);
    check("rp_first_pc4", PCplus4_IF, 32'h4);
    check("rp_first_instr", Instr_IF, word_of(32'h0));
    repeat (10) tick();

    check("sb_activity", {31'd0, (pops >= 20)}, 32'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
